// File: rtl/lr35902_dma_pkg.sv
// Shared types and constants for the LR35902 OAM DMA controller.
package lr35902_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  localparam int unsigned OAM_LEN_DEFAULT = 160;
  localparam int unsigned CTR_W           = 4;

  localparam logic [7:0] ECHO_BASE    = 8'he0;
  localparam logic [7:0] ECHO_OFFSET  = 8'h20;
  localparam logic [7:0] HRAM_IO_PAGE = 8'hff;

  // Echo RAM (E0xx..FFxx source pages) folds back onto WRAM.
  function automatic logic [7:0] eff_src(input logic [7:0] s);
    return (s < ECHO_BASE) ? s : 8'(s - ECHO_OFFSET);
  endfunction

endpackage

// File: rtl/lr35902_dma_slot_ctr.sv
// Modulo-BYTE_CYCLES slot counter, shared by the START slot and every XFER slot.
module lr35902_dma_slot_ctr
  import lr35902_dma_pkg::*;
#(
  parameter int unsigned BYTE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last_cycle,
  output logic next_last
);

  logic [CTR_W-1:0] count;

  // Count through one slot, wrapping to 0 after the last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last_cycle ? '0 : count + CTR_W'(1);
    end
  end

  assign last_cycle = (count == CTR_W'(BYTE_CYCLES - 1));
  // Next cycle is the last one: lets the top register the OAM strobe in advance.
  assign next_last  = (count == CTR_W'(BYTE_CYCLES - 2));

endmodule

// File: rtl/lr35902_oam_dma.sv
// OAM DMA controller and CPU bus arbiter for the LR35902 memory map.
// Optional feature macro: LR35902_OAM_DMA_CPU_BLOCK_EN (CPU access blocking while active).
module lr35902_oam_dma
  import lr35902_dma_pkg::*;
#(
  parameter int unsigned BYTE_CYCLES = 4,
  parameter int unsigned OAM_LEN     = OAM_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  input  logic [15:0] cpu_adr,
  output logic        active,
  output logic        cpu_block,
  output logic [15:0] dma_adr,
  output logic        dma_rd,
  input  logic [7:0]  dma_rdata,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  dma_state_t state;
  logic [7:0] src;
  logic [7:0] idx;
  logic       last_cycle;
  logic       next_last;

  lr35902_dma_slot_ctr #(
    .BYTE_CYCLES(BYTE_CYCLES)
  ) u_slot_ctr (
    .clk       (clk),
    .reset     (reset),
    .clr       (reg_wr),
    .en        (state != IDLE),
    .last_cycle(last_cycle),
    .next_last (next_last)
  );

  // Transfer FSM; bus outputs are registered from the upcoming slot position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      src     <= 8'hff;
      idx     <= 8'h00;
      active  <= 1'b0;
      dma_rd  <= 1'b0;
      dma_adr <= 16'h0000;
      oam_we  <= 1'b0;
      oam_adr <= 8'h00;
    end else if (reg_wr) begin
      // Start or restart: any slot in flight is abandoned here.
      state   <= START;
      src     <= reg_wdata;
      idx     <= 8'h00;
      active  <= 1'b1;
      dma_rd  <= 1'b0;
      dma_adr <= 16'h0000;
      oam_we  <= 1'b0;
      oam_adr <= 8'h00;
    end else begin
      oam_we  <= 1'b0;
      oam_adr <= 8'h00;
      case (state)
        IDLE: begin
        end
        START: begin
          if (last_cycle) begin
            state   <= XFER;
            idx     <= 8'h00;
            dma_rd  <= 1'b1;
            dma_adr <= {eff_src(src), 8'h00};
          end
        end
        XFER: begin
          if (last_cycle) begin
            if (idx == LAST_IDX) begin
              state   <= IDLE;
              idx     <= 8'h00;
              active  <= 1'b0;
              dma_rd  <= 1'b0;
              dma_adr <= 16'h0000;
            end else begin
              idx     <= idx + 8'd1;
              dma_adr <= {eff_src(src), idx + 8'd1};
            end
          end else if (next_last) begin
            oam_we  <= 1'b1;
            oam_adr <= idx;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign reg_rdata = src;
  // Source data is only sampled in the strobe cycle; zero otherwise.
  assign oam_wdata = oam_we ? dma_rdata : 8'h00;

`ifdef LR35902_OAM_DMA_CPU_BLOCK_EN
  // HRAM and IO stay reachable; everything else is owned by the DMA.
  assign cpu_block = active && (cpu_adr[15:8] != HRAM_IO_PAGE);
`else
  logic unused_cpu_adr;
  assign unused_cpu_adr = ^cpu_adr;
  assign cpu_block      = 1'b0;
`endif

endmodule
